// File: rtl/aibcr3_dcc_intp_ctrl_if.sv
// Control/status bundle between the DCC loop controller and its neighbours.
interface aibcr3_dcc_intp_ctrl_if #(
   parameter int unsigned COARSE_W = 3
);
   localparam int unsigned CW = COARSE_W + 3;

   logic                en;
   logic                dcc_up;
   logic                dcc_dn;
   logic                ovrd_en;
   logic [CW-1:0]       ovrd_code;
   logic [2:0]          gray;
   logic [COARSE_W-1:0] coarse;
   logic [CW-1:0]       code;
   logic                locked;
   logic                busy;

   // Side that drives enables/votes and observes the code
   modport master (
      output en, dcc_up, dcc_dn, ovrd_en, ovrd_code,
      input  gray, coarse, code, locked, busy
   );

   // Controller side
   modport slave (
      input  en, dcc_up, dcc_dn, ovrd_en, ovrd_code,
      output gray, coarse, code, locked, busy
   );
endinterface

// File: rtl/aibcr3_dcc_intp_ctrl.sv
// DCC loop controller: filters up/down duty votes over a window and steps a
// {coarse, fine} code by one LSB per window; fine bits leave as Gray code.
module aibcr3_dcc_intp_ctrl #(
   parameter int unsigned COARSE_W   = 3,
   parameter int unsigned INIT_CODE  = 32,
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned WIN_CYC    = 32,
   parameter int unsigned THRESH     = 4,
   parameter int unsigned LOCK_REV   = 4
) (
   input logic                   CLKIN,
   input logic                   RST,
   aibcr3_dcc_intp_ctrl_if.slave ctl
);
   localparam int unsigned CW      = COARSE_W + 3;
   localparam int unsigned ACC_W   = $clog2(WIN_CYC + 1) + 1;
   localparam int unsigned CNT_MAX = (SETTLE_CYC > WIN_CYC) ? SETTLE_CYC : WIN_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned REV_W   = $clog2(LOCK_REV + 1);

   localparam logic [CW-1:0]           INIT_VAL    = CW'(INIT_CODE);
   localparam logic signed [ACC_W-1:0] THR_P       = ACC_W'(THRESH);
   localparam logic signed [ACC_W-1:0] THR_N       = -THR_P;
   localparam logic signed [ACC_W-1:0] VOTE_P      = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] VOTE_N      = -VOTE_P;
   localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]        WIN_LAST    = CNT_W'(WIN_CYC - 1);
   localparam logic [REV_W-1:0]        REV_MAX     = '1;
   localparam logic [REV_W-1:0]        LOCK_VAL    = REV_W'(LOCK_REV);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;
   typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

   state_t                  state;
   dir_t                    last_dir;
   dir_t                    dir_upd;
   logic [CNT_W-1:0]        cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] vote;
   logic [REV_W-1:0]        rev_cnt;
   logic [REV_W-1:0]        rev_upd;
   logic [CW-1:0]           code_q;
   logic [CW-1:0]           step_code;
   logic [2:0]              gray_q;
   logic [COARSE_W-1:0]     coarse_q;
   logic                    locked_q;
   logic                    busy_q;
   logic                    step_up;
   logic                    step_dn;

   function automatic logic [2:0] gray_of(input logic [CW-1:0] c);
      return c[2:0] ^ (c[2:0] >> 1);
   endfunction

   assign ctl.code   = code_q;
   assign ctl.gray   = gray_q;
   assign ctl.coarse = coarse_q;
   assign ctl.locked = locked_q;
   assign ctl.busy   = busy_q;

   // Vote decode and UPDATE-cycle decision: step direction, next code, reversal count
   always_comb begin
      vote      = '0;
      step_up   = 1'b0;
      step_dn   = 1'b0;
      step_code = code_q;
      rev_upd   = rev_cnt;
      dir_upd   = last_dir;
      if (ctl.dcc_up && !ctl.dcc_dn)      vote = VOTE_P;
      else if (ctl.dcc_dn && !ctl.dcc_up) vote = VOTE_N;
      // A step that would leave the code range counts as no step at all
      step_up = (acc > THR_P) && (code_q != '1);
      step_dn = (acc < THR_N) && (code_q != '0);
      if (step_up) step_code = code_q + CW'(1);
      if (step_dn) step_code = code_q - CW'(1);
      if (step_up || step_dn) begin
         dir_upd = step_up ? DIR_UP : DIR_DN;
         if (last_dir == dir_upd)
            rev_upd = '0;
         else if (last_dir != DIR_NONE)
            rev_upd = (rev_cnt == REV_MAX) ? rev_cnt : rev_cnt + REV_W'(1);
      end
   end

   // Loop FSM with reset > override > disable > normal sequencing priority
   always_ff @(posedge CLKIN) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         rev_cnt  <= '0;
         last_dir <= DIR_NONE;
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
         code_q   <= INIT_VAL;
         gray_q   <= gray_of(INIT_VAL);
         coarse_q <= INIT_VAL[CW-1:3];
      end else if (ctl.ovrd_en) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         rev_cnt  <= '0;
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
         code_q   <= ctl.ovrd_code;
         gray_q   <= gray_of(ctl.ovrd_code);
         coarse_q <= ctl.ovrd_code[CW-1:3];
      end else if (!ctl.en) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         rev_cnt  <= '0;
         last_dir <= DIR_NONE;
         locked_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state  <= SETTLE;
               busy_q <= 1'b1;
               cnt    <= '0;
               acc    <= '0;
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SAMPLE: begin
               acc <= acc + vote;
               if (cnt == WIN_LAST) begin
                  state <= UPDATE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            UPDATE: begin
               state    <= SETTLE;
               cnt      <= '0;
               acc      <= '0;
               code_q   <= step_code;
               gray_q   <= gray_of(step_code);
               coarse_q <= step_code[CW-1:3];
               rev_cnt  <= rev_upd;
               last_dir <= dir_upd;
               if (rev_upd >= LOCK_VAL) locked_q <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aibcr3_dcc_intp_ctrl.sv
// Bench for the DCC loop controller: directed scenarios plus a randomized run
// against a window-level reference model.
module tb_aibcr3_dcc_intp_ctrl;
   localparam int PERIOD = 49;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   kk;

   // Reference model state
   int m_code, m_acc, m_rev, m_last, m_cyc, m_pos, m_dir;
   bit m_locked, m_run;
   logic [2:0] gtab [8];

   aibcr3_dcc_intp_ctrl_if #(.COARSE_W(3)) ifc ();

   aibcr3_dcc_intp_ctrl dut (
      .CLKIN (clk),
      .RST   (rst),
      .ctl   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: time since the loop started picks settle/sample/update slot
   always @(posedge clk) begin
      if (rst) begin
         m_code = 32; m_run = 0; m_acc = 0; m_rev = 0; m_last = 0; m_locked = 0;
      end else if (ifc.ovrd_en) begin
         m_code = int'(ifc.ovrd_code); m_run = 0; m_acc = 0; m_rev = 0; m_locked = 0;
      end else if (!ifc.en) begin
         m_run = 0; m_acc = 0; m_rev = 0; m_last = 0; m_locked = 0;
      end else if (!m_run) begin
         m_run = 1; m_cyc = 0; m_acc = 0;
      end else begin
         m_cyc++;
         m_pos = (m_cyc - 1) % PERIOD;
         if (m_pos >= 16 && m_pos <= 47) begin
            if (ifc.dcc_up && !ifc.dcc_dn) m_acc++;
            if (ifc.dcc_dn && !ifc.dcc_up) m_acc--;
         end
         if (m_pos == 48) begin
            m_dir = (m_acc > 4) ? 1 : (m_acc < -4) ? -1 : 0;
            if (m_code + m_dir < 0 || m_code + m_dir > 63) m_dir = 0;
            m_code += m_dir;
            if (m_dir != 0) begin
               if (m_last == m_dir) m_rev = 0;
               else if (m_last != 0) m_rev++;
               m_last = m_dir;
               if (m_rev >= 4) m_locked = 1;
            end
            m_acc = 0;
         end
      end
   end

   // Runs n edges with the loop enabled; in-window slot s gets up for s<nup,
   // then dn for the next ndn slots; slots outside the window get random votes
   task automatic drive(input int n, input int nup, input int ndn, input bit both);
      for (int i = 0; i < n; i++) begin
         int pos, s;
         ifc.en      = 1'b1;
         ifc.ovrd_en = 1'b0;
         ifc.dcc_up  = 1'($urandom);
         ifc.dcc_dn  = 1'($urandom);
         if (kk >= 1) begin
            pos = (kk - 1) % PERIOD;
            if (pos >= 16 && pos <= 47) begin
               s = pos - 16;
               if (both) begin
                  ifc.dcc_up = 1'b1;
                  ifc.dcc_dn = 1'b1;
               end else begin
                  ifc.dcc_up = (s < nup);
                  ifc.dcc_dn = (s >= nup) && (s < nup + ndn);
               end
            end
         end
         @(posedge clk);
         kk++;
         @(negedge clk);
      end
   endtask

   task automatic idle_cycle();
      ifc.en = 1'b0; ifc.ovrd_en = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic force_code(input logic [5:0] c);
      ifc.en = 1'b0; ifc.ovrd_en = 1'b1; ifc.ovrd_code = c;
      @(posedge clk); @(negedge clk);
      ifc.ovrd_en = 1'b0;
      idle_cycle();
      kk = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ifc.en = 0; ifc.dcc_up = 0; ifc.dcc_dn = 0; ifc.ovrd_en = 0; ifc.ovrd_code = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (ifc.code !== 6'd32) begin errors++; $display("FAIL reset_code got %0d expected 32", ifc.code); end
      checks++; if (ifc.gray !== 3'b000) begin errors++; $display("FAIL reset_gray got %b expected 000", ifc.gray); end
      checks++; if (ifc.coarse !== 3'b100) begin errors++; $display("FAIL reset_coarse got %b expected 100", ifc.coarse); end
      checks++; if (ifc.locked !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_flags got locked=%b busy=%b expected 0 0", ifc.locked, ifc.busy); end
      for (int i = 0; i < 5; i++) begin
         idle_cycle();
         checks++; if (ifc.code !== 6'd32 || ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_stable got code=%0d busy=%b expected 32 0", ifc.code, ifc.busy); end
      end
   endtask

   task automatic test_step_up();
      kk = 0;
      drive(49, 32, 0, 0);
      checks++; if (ifc.code !== 6'd32) begin errors++; $display("FAIL step_early got %0d expected 32", ifc.code); end
      checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL step_busy got %b expected 1", ifc.busy); end
      drive(1, 32, 0, 0);
      checks++; if (ifc.code !== 6'd33 || ifc.gray !== 3'b001) begin errors++; $display("FAIL step_33 got code=%0d gray=%b expected 33 001", ifc.code, ifc.gray); end
      drive(48, 32, 0, 0);
      checks++; if (ifc.code !== 6'd33) begin errors++; $display("FAIL step_hold got %0d expected 33", ifc.code); end
      drive(1, 32, 0, 0);
      checks++; if (ifc.code !== 6'd34 || ifc.gray !== 3'b011) begin errors++; $display("FAIL step_34 got code=%0d gray=%b expected 34 011", ifc.code, ifc.gray); end
      drive(49, 32, 0, 0);
      checks++; if (ifc.code !== 6'd35 || ifc.gray !== 3'b010) begin errors++; $display("FAIL step_35 got code=%0d gray=%b expected 35 010", ifc.code, ifc.gray); end
      drive(5 * 49, 32, 0, 0);
      checks++; if (ifc.code !== 6'd40 || ifc.gray !== 3'b000 || ifc.coarse !== 3'b101) begin errors++; $display("FAIL step_40 got code=%0d gray=%b coarse=%b expected 40 000 101", ifc.code, ifc.gray, ifc.coarse); end
      idle_cycle();
      checks++; if (ifc.busy !== 1'b0 || ifc.code !== 6'd40) begin errors++; $display("FAIL step_disable got busy=%b code=%0d expected 0 40", ifc.busy, ifc.code); end
   endtask

   task automatic test_saturation();
      force_code(6'd63);
      checks++; if (ifc.code !== 6'd63 || ifc.gray !== 3'b100 || ifc.coarse !== 3'b111) begin errors++; $display("FAIL sat_ovrd got code=%0d gray=%b coarse=%b expected 63 100 111", ifc.code, ifc.gray, ifc.coarse); end
      drive(3 * 49 + 1, 32, 0, 0);
      checks++; if (ifc.code !== 6'd63 || ifc.locked !== 1'b0) begin errors++; $display("FAIL sat_top got code=%0d locked=%b expected 63 0", ifc.code, ifc.locked); end
      force_code(6'd0);
      drive(3 * 49 + 1, 0, 32, 0);
      checks++; if (ifc.code !== 6'd0 || ifc.gray !== 3'b000 || ifc.coarse !== 3'b000) begin errors++; $display("FAIL sat_bottom got code=%0d gray=%b coarse=%b expected 0 000 000", ifc.code, ifc.gray, ifc.coarse); end
      idle_cycle();
   endtask

   task automatic test_deadband();
      force_code(6'd32);
      drive(50, 18, 14, 0);
      checks++; if (ifc.code !== 6'd32) begin errors++; $display("FAIL dead_plus4 got %0d expected 32", ifc.code); end
      drive(49, 19, 13, 0);
      checks++; if (ifc.code !== 6'd33) begin errors++; $display("FAIL dead_plus6 got %0d expected 33", ifc.code); end
      drive(49, 0, 0, 1);
      checks++; if (ifc.code !== 6'd33) begin errors++; $display("FAIL dead_both got %0d expected 33", ifc.code); end
      drive(49, 14, 18, 0);
      checks++; if (ifc.code !== 6'd33) begin errors++; $display("FAIL dead_minus4 got %0d expected 33", ifc.code); end
      drive(49, 13, 19, 0);
      checks++; if (ifc.code !== 6'd32) begin errors++; $display("FAIL dead_minus6 got %0d expected 32", ifc.code); end
      idle_cycle();
   endtask

   task automatic test_lock();
      force_code(6'd32);
      drive(50, 32, 0, 0);
      checks++; if (ifc.code !== 6'd33 || ifc.locked !== 1'b0) begin errors++; $display("FAIL lock_u1 got code=%0d locked=%b expected 33 0", ifc.code, ifc.locked); end
      drive(49, 0, 32, 0);
      drive(49, 32, 0, 0);
      drive(49, 0, 32, 0);
      checks++; if (ifc.code !== 6'd32 || ifc.locked !== 1'b0) begin errors++; $display("FAIL lock_u4 got code=%0d locked=%b expected 32 0", ifc.code, ifc.locked); end
      drive(49, 32, 0, 0);
      checks++; if (ifc.code !== 6'd33 || ifc.locked !== 1'b1) begin errors++; $display("FAIL lock_u5 got code=%0d locked=%b expected 33 1", ifc.code, ifc.locked); end
      drive(49, 0, 32, 0);
      checks++; if (ifc.code !== 6'd32 || ifc.locked !== 1'b1) begin errors++; $display("FAIL lock_track got code=%0d locked=%b expected 32 1", ifc.code, ifc.locked); end
      idle_cycle();
      checks++; if (ifc.code !== 6'd32 || ifc.locked !== 1'b0 || ifc.busy !== 1'b0) begin errors++; $display("FAIL lock_drop got code=%0d locked=%b busy=%b expected 32 0 0", ifc.code, ifc.locked, ifc.busy); end
   endtask

   task automatic test_reset_mid_sample();
      force_code(6'd40);
      drive(37, 32, 0, 0);
      rst = 1'b1; ifc.en = 1'b1; ifc.dcc_up = 1'b1; ifc.dcc_dn = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0; ifc.en = 1'b0;
      checks++; if (ifc.code !== 6'd32 || ifc.busy !== 1'b0 || ifc.locked !== 1'b0) begin errors++; $display("FAIL rstmid got code=%0d busy=%b locked=%b expected 32 0 0", ifc.code, ifc.busy, ifc.locked); end
      repeat (60) idle_cycle();
      checks++; if (ifc.code !== 6'd32 || ifc.busy !== 1'b0) begin errors++; $display("FAIL rstmid_hold got code=%0d busy=%b expected 32 0", ifc.code, ifc.busy); end
   endtask

   task automatic test_random();
      int bias;
      bias = 50;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (i % PERIOD == 0) bias = 50 * int'($urandom_range(2));
         ifc.en        = ($urandom_range(1999) != 0);
         ifc.ovrd_en   = ($urandom_range(799) == 0);
         ifc.ovrd_code = 6'($urandom);
         rst           = ($urandom_range(2999) == 0);
         ifc.dcc_up    = (int'($urandom_range(99)) < bias);
         ifc.dcc_dn    = (int'($urandom_range(99)) >= bias) || ($urandom_range(9) == 0);
         @(posedge clk); @(negedge clk);
         checks++; if (ifc.code !== 6'(m_code)) begin errors++; $display("FAIL rand_code cyc %0d got %0d expected %0d", i, ifc.code, m_code); end
         checks++; if (ifc.gray !== gtab[m_code % 8]) begin errors++; $display("FAIL rand_gray cyc %0d got %b expected %b", i, ifc.gray, gtab[m_code % 8]); end
         checks++; if (ifc.coarse !== 3'(m_code / 8)) begin errors++; $display("FAIL rand_coarse cyc %0d got %0d expected %0d", i, ifc.coarse, m_code / 8); end
         checks++; if (ifc.locked !== m_locked) begin errors++; $display("FAIL rand_locked cyc %0d got %b expected %b", i, ifc.locked, m_locked); end
         checks++; if (ifc.busy !== m_run) begin errors++; $display("FAIL rand_busy cyc %0d got %b expected %b", i, ifc.busy, m_run); end
      end
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      kk     = 0;
      gtab   = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
      test_reset();
      test_step_up();
      test_saturation();
      test_deadband();
      test_lock();
      test_reset_mid_sample();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
